// File: rtl/axi4_stream_split_sched_pkg.sv
// Shared types and helpers for the packet-level splitter scheduler.
package axi4_stream_split_sched_pkg;

  typedef enum logic [1:0] {
    IDLE_S  = 2'd0,
    FWD_S   = 2'd1,
    DRAIN_S = 2'd2
  } state_t;

  // Callers zero-extend their tkeep to POP_IN_W; covers tdata up to 2048 bits.
  localparam int POP_IN_W  = 256;
  localparam int POP_OUT_W = 9;

  function automatic logic [POP_OUT_W-1:0] popcount(input logic [POP_IN_W-1:0] v);
    logic [POP_OUT_W-1:0] c;
    c = '0;
    for (int i = 0; i < POP_IN_W; i++) c = c + POP_OUT_W'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/axi4_stream_if.sv
// Plain AXI4-Stream bundle with master/slave views.
interface axi4_stream_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int DEST_WIDTH = 1,
  parameter int USER_WIDTH = 1
);
  localparam int DATA_WIDTH_B = DATA_WIDTH / 8;

  logic                    tvalid;
  logic                    tready;
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH_B-1:0] tkeep;
  logic [DATA_WIDTH_B-1:0] tstrb;
  logic                    tlast;
  logic [ID_WIDTH-1:0]     tid;
  logic [DEST_WIDTH-1:0]   tdest;
  logic [USER_WIDTH-1:0]   tuser;

  modport master (output tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser,
                  input  tready);
  modport slave  (input  tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser,
                  output tready);
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester strictly after last_grant, cyclically.
module rr_arbiter #(
  parameter  int N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  // Walk from farthest to nearest so the nearest requester is the last write.
  always_comb begin
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int i = N_REQ; i >= 1; i--) begin
      if (req[(int'(last_grant) + i) % N_REQ]) begin
        grant_idx   = IDX_W'((int'(last_grant) + i) % N_REQ);
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi4_stream_split_sched.sv
// Grants one shared packet splitter to N_SRC streams, one packet at a time,
// and holds the splitter's size limit until its output has drained the packet.
module axi4_stream_split_sched
  import axi4_stream_split_sched_pkg::*;
#(
  parameter int N_SRC          = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int ID_WIDTH       = 4,
  parameter int DEST_WIDTH     = 1,
  parameter int USER_WIDTH     = 1,
  parameter int MAX_PKT_SIZE_B = 2048,
  parameter int PKT_SIZE_WIDTH = $clog2(MAX_PKT_SIZE_B),
  parameter int MAX_IN_PKT_B   = 65536,
  parameter int CNT_WIDTH      = $clog2(MAX_IN_PKT_B) + 1
) (
  input  logic                                  clk_i,
  input  logic                                  rst_n_i,
  input  logic [N_SRC-1:0][PKT_SIZE_WIDTH:0]    src_max_pkt_size_i,
  axi4_stream_if.slave                          pkt_i [N_SRC],
  axi4_stream_if.master                         pkt_o,
  output logic [PKT_SIZE_WIDTH:0]               split_max_pkt_size_o,
  input  logic                                  mon_tvalid_i,
  input  logic                                  mon_tready_i,
  input  logic                                  mon_tlast_i,
  input  logic [DATA_WIDTH/8-1:0]               mon_tkeep_i,
  output logic [$clog2(N_SRC)-1:0]              grant_o,
  output logic                                  busy_o
);

  localparam int DATA_WIDTH_B = DATA_WIDTH / 8;
  localparam int GRANT_W      = $clog2(N_SRC);
  localparam logic [PKT_SIZE_WIDTH:0] MAX_LIMIT = (PKT_SIZE_WIDTH + 1)'(MAX_PKT_SIZE_B);

  logic [N_SRC-1:0]        src_tvalid, src_tlast, src_tready;
  logic [DATA_WIDTH-1:0]   src_tdata [N_SRC];
  logic [DATA_WIDTH_B-1:0] src_tkeep [N_SRC];
  logic [DATA_WIDTH_B-1:0] src_tstrb [N_SRC];
  logic [DEST_WIDTH-1:0]   src_tdest [N_SRC];
  logic [USER_WIDTH-1:0]   src_tuser [N_SRC];

  for (genvar g = 0; g < N_SRC; g++) begin : g_src
    assign src_tvalid[g]   = pkt_i[g].tvalid;
    assign src_tlast[g]    = pkt_i[g].tlast;
    assign src_tdata[g]    = pkt_i[g].tdata;
    assign src_tkeep[g]    = pkt_i[g].tkeep;
    assign src_tstrb[g]    = pkt_i[g].tstrb;
    assign src_tdest[g]    = pkt_i[g].tdest;
    assign src_tuser[g]    = pkt_i[g].tuser;
    assign pkt_i[g].tready = src_tready[g];
  end

  state_t                  state_q, state_d;
  logic [GRANT_W-1:0]      grant_q, grant_d;
  logic [GRANT_W-1:0]      last_grant_q, last_grant_d;
  logic [PKT_SIZE_WIDTH:0] limit_q, limit_d;
  logic [CNT_WIDTH-1:0]    in_bytes_q, in_bytes_d;
  logic [CNT_WIDTH-1:0]    out_bytes_q, out_bytes_d;

  logic [GRANT_W-1:0]      arb_idx;
  logic                    arb_valid;
  logic [PKT_SIZE_WIDTH:0] arb_limit;
  logic                    fwd_hs, mon_hs;
  logic [CNT_WIDTH-1:0]    in_beat_b, mon_beat_b;

  rr_arbiter #(.N_REQ(N_SRC)) u_arb (
    .req         (src_tvalid),
    .last_grant  (last_grant_q),
    .grant_idx   (arb_idx),
    .grant_valid (arb_valid)
  );

  always_comb begin
    arb_limit = src_max_pkt_size_i[arb_idx];
    if (arb_limit == '0 || arb_limit > MAX_LIMIT) arb_limit = MAX_LIMIT;
  end

  assign pkt_o.tvalid = (state_q == FWD_S) & src_tvalid[grant_q];
  assign pkt_o.tdata  = src_tdata[grant_q];
  assign pkt_o.tkeep  = src_tkeep[grant_q];
  assign pkt_o.tstrb  = src_tstrb[grant_q];
  assign pkt_o.tlast  = src_tlast[grant_q];
  assign pkt_o.tdest  = src_tdest[grant_q];
  assign pkt_o.tuser  = src_tuser[grant_q];
  assign pkt_o.tid    = ID_WIDTH'(grant_q);

  assign fwd_hs     = pkt_o.tvalid & pkt_o.tready;
  assign mon_hs     = mon_tvalid_i & mon_tready_i;
  assign in_beat_b  = CNT_WIDTH'(popcount(POP_IN_W'(src_tkeep[grant_q])));
  assign mon_beat_b = CNT_WIDTH'(popcount(POP_IN_W'(mon_tkeep_i)));

  always_comb begin
    src_tready = '0;
    if (state_q == FWD_S) src_tready[grant_q] = pkt_o.tready;
  end

  // NOTE: every variable gets its hold value first, so no branch can leave one
  // unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    limit_d      = limit_q;
    in_bytes_d   = in_bytes_q;
    out_bytes_d  = out_bytes_q;

    // The splitter can emit early segments while input is still arriving.
    if (state_q != IDLE_S && mon_hs) out_bytes_d = out_bytes_q + mon_beat_b;

    unique case (state_q)
      IDLE_S: begin
        if (arb_valid) begin
          grant_d      = arb_idx;
          last_grant_d = arb_idx;
          limit_d      = arb_limit;
          in_bytes_d   = '0;
          out_bytes_d  = '0;
          state_d      = FWD_S;
        end
      end
      FWD_S: begin
        if (fwd_hs) begin
          in_bytes_d = in_bytes_q + in_beat_b;
          if (pkt_o.tlast) state_d = DRAIN_S;
        end
      end
      DRAIN_S: begin
        // Intermediate segment tlasts fall short of the input total.
        if (mon_hs && mon_tlast_i && (out_bytes_q + mon_beat_b == in_bytes_q))
          state_d = IDLE_S;
      end
      default: state_d = IDLE_S;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of the others regardless of process ordering.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE_S;
      grant_q      <= '0;
      last_grant_q <= GRANT_W'(N_SRC - 1);
      limit_q      <= MAX_LIMIT;
      in_bytes_q   <= '0;
      out_bytes_q  <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      limit_q      <= limit_d;
      in_bytes_q   <= in_bytes_d;
      out_bytes_q  <= out_bytes_d;
    end
  end

  assign split_max_pkt_size_o = limit_q;
  assign grant_o              = grant_q;
  assign busy_o               = (state_q != IDLE_S);

endmodule

// File: tb/tb_axi4_stream_split_sched.sv
// Scoreboard bench: per-source drivers, a splitter stand-in on pkt_o that feeds
// the monitor tap, and a monitor that checks every forwarded beat in order.
module tb_axi4_stream_split_sched;

  localparam int N_SRC = 4;
  localparam int DW    = 32;
  localparam int KW    = DW / 8;
  localparam int IDW   = 4;
  localparam int LW    = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N_SRC-1:0][LW-1:0] src_lim;
  logic [LW-1:0]            split_lim;
  logic                     mon_tvalid = 1'b0, mon_tready = 1'b0, mon_tlast = 1'b0;
  logic [KW-1:0]            mon_tkeep = '0;
  logic [1:0]               grant;
  logic                     busy;
  logic [N_SRC-1:0]         src_rdy;

  axi4_stream_if #(.DATA_WIDTH(DW), .ID_WIDTH(IDW), .DEST_WIDTH(1), .USER_WIDTH(1)) src_if [N_SRC] ();
  axi4_stream_if #(.DATA_WIDTH(DW), .ID_WIDTH(IDW), .DEST_WIDTH(1), .USER_WIDTH(1)) out_if ();

  axi4_stream_split_sched #(.N_SRC(N_SRC), .DATA_WIDTH(DW), .ID_WIDTH(IDW)) dut (
    .clk_i                (clk),
    .rst_n_i              (rst_n),
    .src_max_pkt_size_i   (src_lim),
    .pkt_i                (src_if),
    .pkt_o                (out_if),
    .split_max_pkt_size_o (split_lim),
    .mon_tvalid_i         (mon_tvalid),
    .mon_tready_i         (mon_tready),
    .mon_tlast_i          (mon_tlast),
    .mon_tkeep_i          (mon_tkeep),
    .grant_o              (grant),
    .busy_o               (busy)
  );

  typedef struct packed {logic [DW-1:0] data; logic [KW-1:0] keep; logic last;} beat_t;
  typedef struct packed {logic [IDW-1:0] tid; logic [DW-1:0] data; logic [KW-1:0] keep;
                         logic last; logic [LW-1:0] lim;} exp_t;
  typedef struct packed {logic [KW-1:0] keep; logic last;} mon_t;

  beat_t src_q [N_SRC][$];
  exp_t  sb_q[$];
  mon_t  mon_q[$];
  int    hs_cyc[$];
  int    n_checks = 0, n_fail = 0;
  int    cycle = 0;
  bit    rand_rdy = 1'b0, mon_hold = 1'b0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [LW-1:0] clamp(input logic [LW-1:0] v);
    return (v == '0 || v > 12'd2048) ? 12'd2048 : v;
  endfunction

  for (genvar g = 0; g < N_SRC; g++) begin : g_drv
    assign src_rdy[g] = src_if[g].tready;
    initial begin
      bit hs;
      src_if[g].tvalid = 1'b0; src_if[g].tdata = '0; src_if[g].tkeep = '0;
      src_if[g].tstrb = '0; src_if[g].tlast = 1'b0; src_if[g].tid = '0;
      src_if[g].tdest = 1'(g); src_if[g].tuser = 1'(g);
      forever begin
        @(negedge clk);
        hs = src_if[g].tvalid && src_if[g].tready;
        @(posedge clk); #1;
        if (hs && src_q[g].size() > 0) void'(src_q[g].pop_front());
        if (src_q[g].size() > 0) begin
          src_if[g].tvalid = 1'b1;
          src_if[g].tdata  = src_q[g][0].data;
          src_if[g].tkeep  = src_q[g][0].keep;
          src_if[g].tstrb  = src_q[g][0].keep;
          src_if[g].tlast  = src_q[g][0].last;
        end else begin
          src_if[g].tvalid = 1'b0;
        end
      end
    end
  end

  // Checks forwarded beats and acts as the splitter, queueing its output beats.
  initial begin : out_side
    int   seg;
    exp_t e;
    seg = 0;
    out_if.tready = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n) seg = 0;
      else if (out_if.tvalid && out_if.tready) begin
        hs_cyc.push_back(cycle);
        if (sb_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_beat: got tid %0d, expected no beat", out_if.tid);
          e = '0;
          e.lim = 12'd2048;
        end else begin
          e = sb_q.pop_front();
          check("beat_tid",   32'(out_if.tid),   32'(e.tid));
          check("beat_tdest", 32'(out_if.tdest), 32'(e.tid[0]));
          check("beat_tdata", out_if.tdata,      e.data);
          check("beat_tkeep", 32'(out_if.tkeep), 32'(e.keep));
          check("beat_tlast", 32'(out_if.tlast), 32'(e.last));
          check("beat_limit", 32'(split_lim),    32'(e.lim));
        end
        seg += $countones(out_if.tkeep);
        mon_q.push_back('{keep: out_if.tkeep, last: out_if.tlast || (seg >= int'(e.lim))});
        if (out_if.tlast || seg >= int'(e.lim)) seg = 0;
      end
      @(posedge clk); #1;
      out_if.tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin : mon_side
    bit hs;
    forever begin
      @(negedge clk);
      hs = mon_tvalid && mon_tready;
      @(posedge clk); #1;
      if (hs && mon_q.size() > 0) void'(mon_q.pop_front());
      if (mon_q.size() > 0) begin
        mon_tvalid = 1'b1; mon_tkeep = mon_q[0].keep; mon_tlast = mon_q[0].last;
      end else begin
        mon_tvalid = 1'b0; mon_tkeep = '0; mon_tlast = 1'b0;
      end
      mon_tready = mon_hold ? 1'b0 : (rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
    end
  end

  // Cycle invariants: only the granted source sees tready; limit frozen while busy.
  initial begin : inv
    logic [LW-1:0] lim_rec;
    bit            was_busy;
    lim_rec = '0; was_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) was_busy = 1'b0;
      else begin
        check("non_granted_tready", 32'(src_rdy & ~(4'(1) << grant)), 32'd0);
        if (busy && was_busy) check("limit_stable", 32'(split_lim), 32'(lim_rec));
        if (!busy) check("idle_tvalid", 32'(out_if.tvalid), 32'd0);
        lim_rec  = split_lim;
        was_busy = busy;
      end
    end
  end

  task automatic push_pkt(input int src, input int nbytes, input logic [LW-1:0] lim);
    int    nb;
    beat_t b;
    exp_t  e;
    nb = (nbytes + KW - 1) / KW;
    for (int i = 0; i < nb; i++) begin
      int rem;
      rem    = nbytes - i * KW;
      b.data = $urandom();
      b.keep = (rem >= KW) ? 4'hF : 4'((1 << rem) - 1);
      b.last = (i == nb - 1);
      src_q[src].push_back(b);
      e.tid = IDW'(src); e.data = b.data; e.keep = b.keep; e.last = b.last; e.lim = lim;
      sb_q.push_back(e);
    end
  endtask

  task automatic wait_done(input string name, input int max_cyc);
    int n;
    bit pend;
    n = 0;
    forever begin
      pend = busy || (sb_q.size() != 0) || (mon_q.size() != 0);
      for (int k = 0; k < N_SRC; k++) if (src_q[k].size() != 0) pend = 1'b1;
      if (!pend || n >= max_cyc) break;
      @(negedge clk);
      n++;
    end
    check({name, "_complete"}, 32'(n < max_cyc), 32'd1);
  endtask

  task automatic wait_sb(input string name, input int left, input int max_cyc);
    int n;
    n = 0;
    while (sb_q.size() > left && n < max_cyc) begin @(negedge clk); n++; end
    check({name, "_progress"}, 32'(n < max_cyc), 32'd1);
  endtask

  task automatic flush();
    for (int k = 0; k < N_SRC; k++) src_q[k].delete();
    sb_q.delete();
    mon_q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flush();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin : main
    int             sel;
    logic [LW-1:0]  raw;
    src_lim = '0;
    rst_n   = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy",   32'(busy),          32'd0);
    check("reset_grant",  32'(grant),         32'd0);
    check("reset_limit",  32'(split_lim),     32'd2048);
    check("reset_tvalid", 32'(out_if.tvalid), 32'd0);
    check("reset_tready", 32'(src_rdy),       32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Two 10-byte packets: source 0 (limit 4) first, then source 2 (limit 8).
    src_lim[0] = 12'd4; src_lim[2] = 12'd8;
    push_pkt(0, 10, 12'd4);
    push_pkt(2, 10, 12'd8);
    wait_done("two_src", 200);
    check("two_src_last_grant", 32'(grant), 32'd2);

    // All sources valid with 1-beat packets: strict rotation, 3-cycle pitch.
    do_reset();
    for (int k = 0; k < N_SRC; k++) src_lim[k] = 12'd16;
    hs_cyc.delete();
    for (int r = 0; r < 2; r++)
      for (int s = 0; s < N_SRC; s++) push_pkt(s, 4, 12'd16);
    wait_done("rotation", 300);
    check("rotation_beats", 32'(hs_cyc.size()), 32'd8);
    for (int i = 1; i < hs_cyc.size(); i++)
      check("rotation_gap", 32'(hs_cyc[i] - hs_cyc[i-1]), 32'd3);

    // Limit 0 clamps to 2048; 9-byte packet drains on its single tlast.
    do_reset();
    src_lim[1] = 12'd0;
    push_pkt(1, 9, 12'd2048);
    wait_done("clamp_zero", 100);
    check("clamp_zero_grant", 32'(grant), 32'd1);

    // Backpressure on both sides, 1000 packets with assorted limits.
    do_reset();
    rand_rdy = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      sel = $urandom_range(0, 3);
      raw = (sel == 0) ? 12'd0 : (sel == 1) ? 12'd3000 : 12'($urandom_range(1, 64));
      src_lim[i % N_SRC] = raw;
      push_pkt(i % N_SRC, $urandom_range(1, 16), clamp(raw));
      wait_done("random", 500);
    end
    rand_rdy = 1'b0;

    // Source 3 requests while source 0 is draining: it must wait for busy to fall.
    do_reset();
    src_lim[0] = 12'd8; src_lim[3] = 12'd8;
    mon_hold = 1'b1;
    push_pkt(0, 8, 12'd8);
    wait_sb("drain_hold", 0, 50);
    @(negedge clk);
    push_pkt(3, 4, 12'd8);
    repeat (5) begin
      @(negedge clk);
      check("drain_busy",        32'(busy),       32'd1);
      check("drain_grant",       32'(grant),      32'd0);
      check("drain_src3_tready", 32'(src_rdy[3]), 32'd0);
    end
    mon_hold = 1'b0;
    wait_done("drain_hold", 100);
    check("drain_next_grant", 32'(grant), 32'd3);

    // Reset mid-FWD_S: outputs fall asynchronously, then lowest requester wins.
    do_reset();
    src_lim[2] = 12'd8;
    push_pkt(2, 12, 12'd8);
    wait_sb("mid_reset", 2, 50);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("async_busy",   32'(busy),          32'd0);
    check("async_grant",  32'(grant),         32'd0);
    check("async_limit",  32'(split_lim),     32'd2048);
    check("async_tvalid", 32'(out_if.tvalid), 32'd0);
    check("async_tready", 32'(src_rdy),       32'd0);
    flush();
    repeat (2) @(negedge clk);
    src_lim[1] = 12'd4; src_lim[3] = 12'd4;
    push_pkt(1, 4, 12'd4);
    push_pkt(3, 4, 12'd4);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_done("after_reset", 100);
    check("after_reset_grant", 32'(grant), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi4_stream_split_sched.md
# axi4_stream_split_sched

Packet-level scheduler that shares one `axi4_stream_pkt_split` instance between N_SRC AXI4-Stream sources. It grants the splitter to one source per packet in round-robin order and muxes that source onto the splitter input. It drives the splitter's `max_pkt_size_i` with the granted source's limit. It holds that limit stable until the splitter has emitted every byte of the packet, monitored passively on the splitter output.

## Interface
- `N_SRC`, 4, number of requesting sources (2..16)
- `DATA_WIDTH`, 32, tdata width in bits; `DATA_WIDTH_B = DATA_WIDTH/8`
- `ID_WIDTH`, 4, tid width; must be ≥ `$clog2(N_SRC)`
- `DEST_WIDTH`, 1, tdest width
- `USER_WIDTH`, 1, tuser width
- `MAX_PKT_SIZE_B`, 2048, largest splitter segment size
- `PKT_SIZE_WIDTH`, `$clog2(MAX_PKT_SIZE_B)`, splitter size field width
- `MAX_IN_PKT_B`, 65536, largest supported input packet
- `CNT_WIDTH`, `$clog2(MAX_IN_PKT_B)+1`, byte counter width
- `clk_i`  in  1  single clock
- `rst_n_i`  in  1  reset; asynchronous, active-low
- `src_max_pkt_size_i`  in  N_SRC×(PKT_SIZE_WIDTH+1)  per-source segment limit
- `pkt_i[N_SRC]`  slave `axi4_stream_if`  source streams
- `pkt_o`  master `axi4_stream_if`  to the splitter `pkt_i`
- `split_max_pkt_size_o`  out  PKT_SIZE_WIDTH+1  to the splitter `max_pkt_size_i`
- `mon_tvalid_i`, `mon_tready_i`, `mon_tlast_i`  in  1 each  splitter output tap
- `mon_tkeep_i`  in  DATA_WIDTH_B  splitter output tap
- `grant_o`  out  `$clog2(N_SRC)`  current or last granted source
- `busy_o`  out  1  high outside IDLE_S

## Operation
- **States.**
  - IDLE_S: arbitrate, then go to FWD_S.
  - FWD_S: forward the packet; on the `pkt_o` handshake with tlast, go to DRAIN_S.
  - DRAIN_S: wait until the splitter has emitted every byte, then go to IDLE_S.
- **Arbitration (IDLE_S).**
  - Requesters are sources with `pkt_i[k].tvalid`.
  - The winner is the first requester strictly after `last_grant`, in cyclic order.
  - Register `grant_o` and `last_grant`, latch the clamped limit, clear both counters, then enter FWD_S.
  - With no requester, stay in IDLE_S.
- **Limit clamp.** A value of 0 or > `MAX_PKT_SIZE_B` is replaced by `MAX_PKT_SIZE_B`.
  - `split_max_pkt_size_o` changes only on the IDLE_S→FWD_S transition.
- **FWD_S (combinational mux).**
  - `pkt_o.{tvalid,tdata,tkeep,tstrb,tlast,tdest,tuser}` = `pkt_i[grant]`.
  - `pkt_o.tid` = zero-extended `grant`.
  - `pkt_i[grant].tready = pkt_o.tready`; all other `tready` are 0.
  - `in_bytes += popcount(tkeep)` on each handshake.
- **DRAIN_S.**
  - `pkt_o.tvalid` = 0 and every `pkt_i[k].tready` = 0.
  - On each monitor handshake (`mon_tvalid_i & mon_tready_i`), `out_bytes += popcount(mon_tkeep_i)`.
  - Exit when a monitor handshake carries `mon_tlast_i` and `out_bytes + popcount(mon_tkeep_i) == in_bytes`.
  - Earlier monitor tlasts are intermediate segments and are ignored.
- **Counting during FWD_S.** Monitor handshakes during FWD_S also count into `out_bytes`; the splitter may emit segments before the input tlast.
- **Counter arithmetic.**
  - Unsigned, CNT_WIDTH bits, modulo 2^CNT_WIDTH.
  - Packets larger than `MAX_IN_PKT_B` are unsupported; both counters wrap identically.
- **Simultaneous events.**
  - A request arriving during FWD_S or DRAIN_S waits.
  - A monitor handshake in the same cycle as the FWD_S→DRAIN_S transition is counted.

## Timing
- **Reset values.**
  - State: IDLE_S; `busy_o` = 0; `grant_o` = 0.
  - `last_grant` = N_SRC−1, so source 0 wins first.
  - Counters: 0; `split_max_pkt_size_o` = `MAX_PKT_SIZE_B`.
  - `pkt_o.tvalid` = 0; all `tready` = 0.
- **Arbitration latency.** 1 cycle: tvalid seen in IDLE_S, first beat can transfer the next cycle.
- **Forwarding.** Zero-latency combinational path in FWD_S; full throughput.
- **Packet-to-packet gap.** At least 2 cycles (DRAIN_S exit, then IDLE_S).
  - DRAIN_S exits in the cycle after the final monitor handshake.
- **Reset mid-packet.** Abort immediately and drop all `tready`. The splitter is reset by the same reset domain.

## Structure
- **Package `axi4_stream_split_sched_pkg`.**
  - `state_t` enum {IDLE_S, FWD_S, DRAIN_S}.
  - Function `popcount`, parameterised by width.
- **Sub-module `rr_arbiter`.**
  - Inputs: `req[N_SRC]`, `last_grant`.
  - Outputs: `grant_idx`, `grant_valid`.
  - Purely combinational, reusable.

## Test plan
- Sources 0 and 2 each send one 10-byte packet; limits 4 and 8; `DATA_WIDTH` 32 → source 0 first with `split_max_pkt_size_o`=4 and tid=0. The monitor sees segments 4/4/2 before source 2 is granted with limit 8, giving segments 8/2.
- All 4 sources continuously valid, 1-beat packets → grants 0,1,2,3,0,… with exactly a 2-cycle gap between packets.
- Source 1 sends 9 bytes (3 beats, last tkeep=0001) with limit 0 → limit clamped to 2048. DRAIN_S exits on the single monitor tlast at 9 bytes.
- Random `pkt_o.tready` and monitor backpressure, 1000 packets → no data, tkeep or tlast lost. The limit never changes between grant and drain completion, and non-granted `tready` is always 0.
- Source 3 requests while source 0 is in DRAIN_S → source 3 stays unserved until `busy_o` falls, then is granted.
- `rst_n_i` asserted mid-FWD_S → outputs return to reset values asynchronously. The first grant after release goes to the lowest-index requester.
